// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppu_pkg
// Purpose  : Shared constants and FSM state type for the PPU VRAM port.
//            Optional feature macro: PPU_PALETTE_DIRECT_READ_EN
// Revision : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    localparam logic [2:0]  REG_STATUS = 3'd2;
    localparam logic [2:0]  REG_ADDR   = 3'd6;
    localparam logic [2:0]  REG_DATA   = 3'd7;

    localparam logic [5:0]  PALETTE_HI = 6'h3F;
    localparam logic [13:0] SHADOW_OFS = 14'h1000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MEM    = 3'd1,
        ST_RD_MEM    = 3'd2,
        ST_ACK       = 3'd3
`ifdef PPU_PALETTE_DIRECT_READ_EN
        ,
        ST_RD_SHADOW = 3'd4
`endif
    } port_state_t;

endpackage
`default_nettype wire

// File: rtl/ppu_addr_latch.sv
`default_nettype none
// ============================================================================
// Module   : ppu_addr_latch
// Purpose  : PPUADDR two-write latch (w toggle, high-byte holding register)
//            and the VRAM address register with modulo auto-increment.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_addr_latch #(
    parameter int ADDR_W  = 14,
    parameter int INC_BIG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_hi,
    input  logic              load_lo,
    input  logic              clr_w,
    input  logic              inc,
    input  logic              inc32,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] addr,
    output logic              w
);

    localparam int HI_W = ADDR_W - 8;

    logic [HI_W-1:0]   r_addr_hi_tmp;
    logic [ADDR_W-1:0] w_step;

    // The add naturally wraps at 2^ADDR_W, matching the 14-bit PPU bus.
    assign w_step = inc32 ? ADDR_W'(INC_BIG) : ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_hi_tmp <= '0;
            addr          <= '0;
            w             <= 1'b0;
        end else begin
            if (load_hi) begin
                r_addr_hi_tmp <= din[HI_W-1:0];
                w             <= 1'b1;
            end else if (load_lo || clr_w) begin
                w <= 1'b0;
            end

            if (load_lo) begin
                addr <= {r_addr_hi_tmp, din};
            end else if (inc) begin
                addr <= addr + w_step;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_vram_port.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_port
// Purpose  : CPU-facing PPUADDR/PPUDATA port with buffered reads, auto-
//            increment and a req/ack handshake towards PPU memory.
//            Optional feature macro: PPU_PALETTE_DIRECT_READ_EN
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int INC_BIG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [2:0]  cpu_reg,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_busy,
    input  logic        ctrl_inc32,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    port_state_t       r_state;
    logic [7:0]        r_read_buf;
    logic [7:0]        r_dout_hold;

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_mem_addr_int;
    logic              w_toggle;
    logic              w_accept;
    logic              w_load_hi;
    logic              w_load_lo;
    logic              w_clr_w;
    logic              w_inc;
    logic              w_mem_done;

    assign w_accept   = cpu_req && (r_state == ST_IDLE);
    assign w_load_hi  = w_accept &&  cpu_we && (cpu_reg == REG_ADDR) && !w_toggle;
    assign w_load_lo  = w_accept &&  cpu_we && (cpu_reg == REG_ADDR) &&  w_toggle;
    assign w_clr_w    = w_accept && !cpu_we && (cpu_reg == REG_STATUS);
    assign w_mem_done = mem_req && mem_ack;

`ifdef PPU_PALETTE_DIRECT_READ_EN
    logic r_pal;

    // A palette read increments only after its shadow nametable read.
    assign w_inc = w_mem_done && ((r_state == ST_WR_MEM) ||
                                  ((r_state == ST_RD_MEM) && !r_pal) ||
                                  (r_state == ST_RD_SHADOW));
    assign w_mem_addr_int = (r_state == ST_RD_SHADOW) ? (w_addr - SHADOW_OFS) : w_addr;
`else
    assign w_inc = w_mem_done && ((r_state == ST_WR_MEM) || (r_state == ST_RD_MEM));
    assign w_mem_addr_int = w_addr;
`endif

    assign mem_addr = {{(16-ADDR_W){1'b0}}, w_mem_addr_int};
    assign cpu_busy = (r_state != ST_IDLE);

    ppu_addr_latch #(
        .ADDR_W  (ADDR_W),
        .INC_BIG (INC_BIG)
    ) u_addr_latch (
        .clk     (clk),
        .rst     (rst),
        .load_hi (w_load_hi),
        .load_lo (w_load_lo),
        .clr_w   (w_clr_w),
        .inc     (w_inc),
        .inc32   (ctrl_inc32),
        .din     (cpu_din),
        .addr    (w_addr),
        .w       (w_toggle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_read_buf  <= 8'h00;
            r_dout_hold <= 8'h00;
            cpu_dout    <= 8'h00;
            cpu_ack     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'h00;
`ifdef PPU_PALETTE_DIRECT_READ_EN
            r_pal       <= 1'b0;
`endif
        end else begin
            cpu_ack  <= 1'b0;
            cpu_dout <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if ((cpu_reg == REG_DATA) && cpu_we) begin
                            r_dout_hold <= 8'h00;
                            mem_we      <= 1'b1;
                            mem_wdata   <= cpu_din;
                            mem_req     <= 1'b1;
                            r_state     <= ST_WR_MEM;
                        end else if (cpu_reg == REG_DATA) begin
                            r_dout_hold <= r_read_buf;
                            mem_we      <= 1'b0;
                            mem_req     <= 1'b1;
`ifdef PPU_PALETTE_DIRECT_READ_EN
                            r_pal       <= (w_addr[ADDR_W-1:8] == PALETTE_HI);
`endif
                            r_state     <= ST_RD_MEM;
                        end else begin
                            r_dout_hold <= 8'h00;
                            cpu_ack     <= 1'b1;
                            r_state     <= ST_ACK;
                        end
                    end
                end
                ST_WR_MEM: begin
                    if (w_mem_done) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        cpu_ack  <= 1'b1;
                        cpu_dout <= r_dout_hold;
                        r_state  <= ST_ACK;
                    end
                end
                ST_RD_MEM: begin
                    if (w_mem_done) begin
                        mem_req <= 1'b0;
`ifdef PPU_PALETTE_DIRECT_READ_EN
                        if (r_pal) begin
                            r_dout_hold <= mem_rdata;
                            r_state     <= ST_RD_SHADOW;
                        end else begin
                            r_read_buf <= mem_rdata;
                            cpu_ack    <= 1'b1;
                            cpu_dout   <= r_dout_hold;
                            r_state    <= ST_ACK;
                        end
`else
                        r_read_buf <= mem_rdata;
                        cpu_ack    <= 1'b1;
                        cpu_dout   <= r_dout_hold;
                        r_state    <= ST_ACK;
`endif
                    end
                end
`ifdef PPU_PALETTE_DIRECT_READ_EN
                ST_RD_SHADOW: begin
                    // One idle cycle separates the palette and shadow requests.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req    <= 1'b0;
                        r_read_buf <= mem_rdata;
                        cpu_ack    <= 1'b1;
                        cpu_dout   <= r_dout_hold;
                        r_state    <= ST_ACK;
                    end
                end
`endif
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ppu_vram_port.md
Name: ppu_vram_port

Overview:
- CPU-facing VRAM access port of the PPU; implements the $2006 (PPUADDR) two-write address latch and the $2007 (PPUDATA) buffered read/write with auto-increment.
- Drives the raw 16-bit PPU address into the PPU memory decoder and exchanges data with PPU memory through a req/ack handshake.
- Sits between the CPU register bus decode and the PPU memory address decoder.

Parameters:
- ADDR_W, 14, width of the internal VRAM address register; mem_addr is zero-extended to 16 bits.
- INC_BIG, 32, increment step applied when ctrl_inc32 = 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  one-cycle request strobe; accepted only when cpu_busy = 0.
- cpu_reg  in  3  PPU register index, meaning address[2:0] of $2000-$2007.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  read data; valid only when cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high when state != IDLE.
- ctrl_inc32  in  1  PPUCTRL bit 2, sampled when the increment is applied.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable; valid while mem_req = 1.
- mem_addr  out  16  {2'b00, addr}; feeds the memory decoder.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid when mem_ack = 1.
- mem_ack  in  1  completion; ignored unless mem_req = 1.

Behaviour:
- Reset values: addr = 0, addr_hi_tmp = 0, w = 0, read_buf = 0, state = IDLE. All outputs reset to 0.
- Reset mid-operation: mem_req drops on the next edge; no cpu_ack is issued; the pending increment is lost.
- States: IDLE, WR_MEM, RD_MEM, RD_SHADOW (feature only), ACK.

IDLE: a cpu_req is acted on by register type.
- Write to reg 6, w = 0: addr_hi_tmp <= cpu_din[5:0]; w <= 1. Bits 7:6 are discarded.
- Write to reg 6, w = 1: addr <= {addr_hi_tmp, cpu_din}; w <= 0.
- Read of reg 2 (status strobe): w <= 0; cpu_dout = 0. The status byte itself is supplied by another block.
- Write to reg 7: mem_we = 1, mem_wdata = cpu_din, mem_req = 1; go to WR_MEM.
- Read of reg 7: latch cpu_dout_reg <= read_buf; mem_we = 0, mem_req = 1; go to RD_MEM.
- Any other register or direction: no effect; cpu_dout = 0; go to ACK.
- All register-6 and register-2 accesses also go to ACK, so every request is acked exactly 1 cycle after acceptance.

WR_MEM:
- On mem_ack: mem_req <= 0; addr <= addr + step; go to ACK.

RD_MEM:
- On mem_ack: read_buf <= mem_rdata; addr <= addr + step; mem_req <= 0; go to ACK.

ACK:
- cpu_ack = 1 for 1 cycle with cpu_dout = cpu_dout_reg; return to IDLE.

Rules:
- step = INC_BIG if ctrl_inc32 else 1. The add is modulo 2^ADDR_W: 0x3FFF+1 -> 0x0000; 0x3FF0+32 -> 0x0010.
- mem_addr reflects addr at the time of the request and is stable while mem_req = 1. The increment is applied in the same edge that clears mem_req.
- $2007 latency: 1 + memory latency + 1 cycles to cpu_ack.
- cpu_req while cpu_busy = 1 is ignored; no state change and no ack.
- A reg-6 write during a reg-7 operation is impossible, because busy blocks it.

Optional Feature:
- Macro: PPU_PALETTE_DIRECT_READ_EN.
- Enabled, applies to a $2007 read with addr[13:8] = 6'h3F:
  - RD_MEM returns mem_rdata directly in cpu_dout_reg and does not load read_buf.
  - The FSM then goes to RD_SHADOW, which issues a second read at addr - 14'h1000 (the nametable under the palette) and loads read_buf with that data.
  - addr is incremented after the second ack; then the FSM goes to ACK.
- Disabled: palette reads are buffered like all other reads. The RD_SHADOW state and its logic are not compiled.

Decomposition:
- Shared package ppu_pkg holds:
  - register index constants: REG_STATUS = 3'd2, REG_ADDR = 3'd6, REG_DATA = 3'd7;
  - PALETTE_HI = 6'h3F and SHADOW_OFS = 14'h1000;
  - the port FSM state enum.
- One natural sub-module, ppu_addr_latch: holds w, addr_hi_tmp and addr, with the load and increment/wrap logic. Its interface is load_hi, load_lo, clr_w, inc, inc32 and din, with output addr.

Test Plan:
- Write $2006=0x21, then $2006=0x08, then $2007=0x55 with ctrl_inc32=0 -> mem write at 0x2108 with data 0x55; addr becomes 0x2109; cpu_ack is 1 cycle after mem_ack.
- After preload with read_buf=0, mem[0x2000]=0xAA, mem[0x2001]=0xBB, read $2007 twice -> returns 0x00 then 0xAA; read_buf = 0xBB; addr = 0x2002.
- Write $2006=0x3F, then read $2002, then write $2006=0x12, then 0x34 -> addr = 0x1234 (the status read reset the toggle).
- With ctrl_inc32=1, set addr 0x3FF0 and write $2007 -> mem_addr = 0x3FF0; addr wraps to 0x0010. Also $2006 written with 0xFF as hi byte -> hi is 0x3F.
- Hold mem_ack low for 5 cycles during a read, assert cpu_req and then rst -> cpu_busy stays 1 and the extra req is ignored; after rst all outputs are 0 and no ack occurs.
- With PPU_PALETTE_DIRECT_READ_EN, mem[0x3F05]=0x11 and mem[0x2F05]=0x22, read $2007 at 0x3F05 -> cpu_dout = 0x11; read_buf = 0x22; second mem_addr = 0x2F05; addr = 0x3F06.
